// File: rtl/driver_pkg.sv
// Shared types and defaults for the driver address sequencer.
// State encoding plus stride and counter width defaults.
package driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } seq_state_e;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned ADDR_STRIDE_DEF = 4;

endpackage

// File: rtl/consec_addr_gen.sv
// Base address register plus run-length counter for consecutive expansion.
// Counter and stride adder exist only when ADDR_SEQ_CONSEC_EN is defined.
module consec_addr_gen
    import driver_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned STRIDE = ADDR_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic              clear,
    input  logic [ADDR_W-1:0] base,
    input  logic [7:0]        count,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

`ifdef ADDR_SEQ_CONSEC_EN
    logic [7:0] rem_q;
    logic [7:0] rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (clear) begin
            rem_d = '0;
        end else if (load) begin
            addr_d = base;
            rem_d  = count;
        end else if (advance && rem_q != 8'd0) begin
            // Wraps silently at the top of the address space.
            addr_d = addr_q + ADDR_W'(STRIDE);
            rem_d  = rem_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign last = (rem_q == 8'd0);
`else
    logic unused_expand;
    assign unused_expand = ^{advance, clear, count};

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = base;
        end
    end

    assign last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/addr_fifo_sequencer.sv
// Address FIFO read-side sequencer: pop, optional expansion, request issue.
// Consecutive expansion is enabled by defining ADDR_SEQ_CONSEC_EN.
module addr_fifo_sequencer
    import driver_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned ADDR_STRIDE = ADDR_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active_program,
    input  logic              abort_program,
    input  logic              freeze_addr_fifo,
    input  logic              send_consec_addr,
    input  logic [7:0]        consec_count,
    input  logic [ADDR_W-1:0] addr_fifo_dout,
    input  logic              addr_fifo_empty,
    output logic              addr_fifo_rd,
    output logic              vctr_req_valid,
    output logic [ADDR_W-1:0] vctr_req_addr,
    input  logic              vctr_req_ready,
    output logic              addr_fifo_underrun,
    output logic [CNT_W-1:0]  addr_cycle_cnt,
    output logic              seq_busy
);

    seq_state_e state_q;
    seq_state_e state_d;

    logic             valid_q;
    logic             valid_d;
    logic             armed_q;
    logic             armed_d;
    logic             unf_q;
    logic             unf_d;
    logic             act_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic       pop;
    logic       hs;
    logic       gen_load;
    logic       gen_adv;
    logic       gen_clr;
    logic       gen_last;
    logic [7:0] count_sel;

`ifdef ADDR_SEQ_CONSEC_EN
    assign count_sel = send_consec_addr ? consec_count : 8'd0;
`else
    logic unused_cfg;
    assign unused_cfg = ^{send_consec_addr, consec_count};
    assign count_sel  = 8'd0;
`endif

    assign hs = valid_q & vctr_req_ready;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        pop      = 1'b0;
        gen_load = 1'b0;
        gen_adv  = 1'b0;
        gen_clr  = 1'b0;
        if (abort_program) begin
            state_d = IDLE;
            valid_d = 1'b0;
            gen_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (active_program) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (!active_program) begin
                        state_d = IDLE;
                    end else if (!addr_fifo_empty && !freeze_addr_fifo) begin
                        pop     = ~reset;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    gen_load = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = ISSUE;
                end
                ISSUE: begin
                    if (hs) begin
                        if (!active_program) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            gen_clr = 1'b1;
                        end else if (!gen_last) begin
                            gen_adv = 1'b1;
                        end else begin
                            state_d = FETCH;
                            valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Underrun fires once per starvation episode, re-armed by a pop or IDLE.
    always_comb begin
        unf_d   = armed_q && !abort_program && (state_q == FETCH)
                  && active_program && !freeze_addr_fifo && addr_fifo_empty;
        armed_d = armed_q;
        if (pop || state_q == IDLE) begin
            armed_d = 1'b1;
        end else if (unf_d) begin
            armed_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (active_program && !act_q) begin
            cnt_d = CNT_W'(1);
        end else if (active_program && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            armed_q <= 1'b1;
            unf_q   <= 1'b0;
            act_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            armed_q <= armed_d;
            unf_q   <= unf_d;
            act_q   <= active_program;
            cnt_q   <= cnt_d;
        end
    end

    consec_addr_gen #(
        .ADDR_W (ADDR_W),
        .STRIDE (ADDR_STRIDE)
    ) u_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (gen_load),
        .advance (gen_adv),
        .clear   (gen_clr),
        .base    (addr_fifo_dout),
        .count   (count_sel),
        .addr    (vctr_req_addr),
        .last    (gen_last)
    );

    assign addr_fifo_rd       = pop;
    assign vctr_req_valid     = valid_q;
    assign addr_fifo_underrun = unf_q;
    assign addr_cycle_cnt     = cnt_q;
    assign seq_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_addr_fifo_sequencer.sv
// Directed bench for addr_fifo_sequencer with a small FIFO model.
// Expansion expectations depend on ADDR_SEQ_CONSEC_EN.
module tb_addr_fifo_sequencer;

    typedef struct {
        logic [31:0]      base;
        logic             consec;
        logic [7:0]       cnt;
        int               n;
        logic [3:0][31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        active_program;
    logic        abort_program;
    logic        freeze_addr_fifo;
    logic        send_consec_addr;
    logic [7:0]  consec_count;
    logic [31:0] addr_fifo_dout = '0;
    logic        addr_fifo_empty;
    logic        addr_fifo_rd;
    logic        vctr_req_valid;
    logic [31:0] vctr_req_addr;
    logic        vctr_req_ready;
    logic        addr_fifo_underrun;
    logic [15:0] addr_cycle_cnt;
    logic        seq_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] fmem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    vec_t tbl [5];

    always #5 clk = ~clk;

    assign addr_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (addr_fifo_rd) begin
            addr_fifo_dout <= fmem[rd_ptr % 16];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    addr_fifo_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .active_program     (active_program),
        .abort_program      (abort_program),
        .freeze_addr_fifo   (freeze_addr_fifo),
        .send_consec_addr   (send_consec_addr),
        .consec_count       (consec_count),
        .addr_fifo_dout     (addr_fifo_dout),
        .addr_fifo_empty    (addr_fifo_empty),
        .addr_fifo_rd       (addr_fifo_rd),
        .vctr_req_valid     (vctr_req_valid),
        .vctr_req_addr      (vctr_req_addr),
        .vctr_req_ready     (vctr_req_ready),
        .addr_fifo_underrun (addr_fifo_underrun),
        .addr_cycle_cnt     (addr_cycle_cnt),
        .seq_busy           (seq_busy)
    );

    task automatic push(input logic [31:0] a);
        fmem[wr_ptr % 16] = a;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] b, input logic c,
                                input logic [7:0] n8, input int n,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.base   = b;
        v.consec = c;
        v.cnt    = n8;
        v.n      = n;
        v.exp    = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic wait_valid(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!vctr_req_valid && k < 10);
        chk(nm, {31'd0, vctr_req_valid}, 32'd1);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int n_exp;
        int beats;
        int rds;
        int last_c;
        int gap_bad;
        v       = tbl[idx];
        n_exp   = v.n;
        beats   = 0;
        rds     = 0;
        last_c  = -1;
        gap_bad = 0;
`ifndef ADDR_SEQ_CONSEC_EN
        n_exp = 1;
`endif
        @(posedge clk); #1;
        send_consec_addr = v.consec;
        consec_count     = v.cnt;
        vctr_req_ready   = 1'b1;
        push(v.base);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (addr_fifo_rd) rds++;
            if (vctr_req_valid && vctr_req_ready) begin
                if (beats < 4)
                    chk($sformatf("vec%0d beat%0d addr", idx, beats),
                        vctr_req_addr, v.exp[beats]);
                if (last_c >= 0 && c - last_c != 1) gap_bad++;
                last_c = c;
                beats++;
            end
        end
        chk($sformatf("vec%0d beats", idx), beats, n_exp);
        chk($sformatf("vec%0d rd pulses", idx), rds, 1);
        chk($sformatf("vec%0d beat gaps", idx), gap_bad, 0);
    endtask

    initial begin
        int rds, rd0, v0, v1, nv, un, k, hs;
        logic [31:0] a0, a1, c0, exp_b2;

        reset            = 1'b1;
        active_program   = 1'b1;
        abort_program    = 1'b0;
        freeze_addr_fifo = 1'b0;
        send_consec_addr = 1'b0;
        consec_count     = 8'd0;
        vctr_req_ready   = 1'b1;

        tbl[0] = mk(32'h0000_A000, 1'b0, 8'd3, 1,
                    32'h0000_A000, 32'h0, 32'h0, 32'h0);
        tbl[1] = mk(32'hFFFF_FFF8, 1'b1, 8'd3, 4,
                    32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004);
        tbl[2] = mk(32'h0000_0100, 1'b1, 8'd0, 1,
                    32'h0000_0100, 32'h0, 32'h0, 32'h0);
        tbl[3] = mk(32'h1234_5670, 1'b1, 8'd2, 3,
                    32'h1234_5670, 32'h1234_5674, 32'h1234_5678, 32'h0);
        tbl[4] = mk(32'h8000_0000, 1'b0, 8'd2, 1,
                    32'h8000_0000, 32'h0, 32'h0, 32'h0);

        push(32'h0000_1000);
        push(32'h0000_2000);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset rd", {31'd0, addr_fifo_rd}, 32'd0);
            chk("reset valid", {31'd0, vctr_req_valid}, 32'd0);
            chk("reset cnt", {16'd0, addr_cycle_cnt}, 32'd0);
            chk("reset busy", {31'd0, seq_busy}, 32'd0);
            chk("reset underrun", {31'd0, addr_fifo_underrun}, 32'd0);
        end
        chk("reset addr", vctr_req_addr, 32'd0);

        @(posedge clk); #1;
        reset = 1'b0;
        rds = 0; rd0 = -1; v0 = -1; v1 = -1; nv = 0; a0 = '0; a1 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (addr_fifo_rd) begin
                rds++;
                if (rd0 < 0) rd0 = c;
            end
            if (vctr_req_valid && vctr_req_ready) begin
                if (nv == 0) begin a0 = vctr_req_addr; v0 = c; end
                if (nv == 1) begin a1 = vctr_req_addr; v1 = c; end
                nv++;
            end
        end
        chk("two pops rd count", rds, 2);
        chk("two pops req count", nv, 2);
        chk("first req addr", a0, 32'h0000_1000);
        chk("second req addr", a1, 32'h0000_2000);
        chk("rd to valid latency", v0 - rd0, 2);
        chk("single req spacing", v1 - v0, 3);

        @(negedge clk);
        c0 = {16'd0, addr_cycle_cnt};
        repeat (5) @(negedge clk);
        chk("cnt increments", {16'd0, addr_cycle_cnt} - c0, 5);

        for (int i = 0; i < 5; i++) run_vec(i);

        @(posedge clk); #1;
        vctr_req_ready   = 1'b0;
        send_consec_addr = 1'b0;
        push(32'h0000_3000);
        wait_valid("stall valid seen");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall valid held", {31'd0, vctr_req_valid}, 32'd1);
            chk("stall addr held", vctr_req_addr, 32'h0000_3000);
        end
        @(posedge clk); #1;
        vctr_req_ready = 1'b1;
        @(negedge clk);
        chk("stall release addr", vctr_req_addr, 32'h0000_3000);
        @(negedge clk);
        chk("stall advanced", {31'd0, vctr_req_valid}, 32'd0);

        @(posedge clk); #1;
        active_program = 1'b0;
        @(negedge clk);
        c0 = {16'd0, addr_cycle_cnt};
        repeat (4) @(negedge clk);
        chk("cnt holds inactive", {16'd0, addr_cycle_cnt}, c0);
        chk("idle busy", {31'd0, seq_busy}, 32'd0);

        @(posedge clk); #1;
        active_program = 1'b1;
        un = 0; rds = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (addr_fifo_underrun) un++;
            if (addr_fifo_rd) rds++;
            if (i == 2)
                chk("cnt restart", {31'd0, (addr_cycle_cnt >= 16'd1 &&
                    addr_cycle_cnt <= 16'd2)}, 32'd1);
        end
        chk("underrun pulses", un, 1);
        chk("underrun no rd", rds, 0);

        @(posedge clk); #1;
        active_program = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        freeze_addr_fifo = 1'b1;
        active_program   = 1'b1;
        un = 0; rds = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (addr_fifo_underrun) un++;
            if (addr_fifo_rd) rds++;
        end
        @(posedge clk); #1;
        push(32'h0000_5000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (addr_fifo_underrun) un++;
            if (addr_fifo_rd) rds++;
        end
        chk("freeze underrun", un, 0);
        chk("freeze rd", rds, 0);
        @(posedge clk); #1;
        freeze_addr_fifo = 1'b0;
        vctr_req_ready   = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(vctr_req_valid && vctr_req_ready) && k < 10);
        chk("unfreeze req seen", {31'd0, vctr_req_valid}, 32'd1);
        chk("unfreeze req addr", vctr_req_addr, 32'h0000_5000);

        @(posedge clk); #1;
        vctr_req_ready   = 1'b0;
        send_consec_addr = 1'b1;
        consec_count     = 8'd7;
        push(32'h0000_6000);
        push(32'h0000_7000);
        push(32'h0000_8000);
        wait_valid("abort valid seen");
        @(posedge clk); #1;
        vctr_req_ready = 1'b1;
        hs = 0; k = 0; a1 = '0;
        while (hs < 2 && k < 12) begin
            @(negedge clk);
            k++;
            if (vctr_req_valid && vctr_req_ready) begin
                hs++;
                if (hs == 2) a1 = vctr_req_addr;
            end
        end
`ifdef ADDR_SEQ_CONSEC_EN
        exp_b2 = 32'h0000_6004;
`else
        exp_b2 = 32'h0000_7000;
`endif
        chk("abort prefix beats", hs, 2);
        chk("abort beat2 addr", a1, exp_b2);
        @(posedge clk); #1;
        abort_program  = 1'b1;
        vctr_req_ready = 1'b0;
        rds = 0;
        @(negedge clk);
        if (addr_fifo_rd) rds++;
        @(negedge clk);
        if (addr_fifo_rd) rds++;
        chk("abort valid low", {31'd0, vctr_req_valid}, 32'd0);
        chk("abort busy low", {31'd0, seq_busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (addr_fifo_rd) rds++;
        end
        chk("abort no rd", rds, 0);
        chk("abort stays idle", {31'd0, seq_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
